// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit (master) and instruction memory (slave).
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches words over a req/ack bus and presents
// the registered instruction and its decoded fields to the controller.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    fetch_unit_if.master        imem,
    input  logic                stall,
    input  logic                PCSrc,
    input  logic [31:0]         Result,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [3:0]          Cond,
    output logic [1:0]          Op,
    output logic [5:0]          Funct,
    output logic [31:0]         pc_plus8,
    output logic                fetch_err
);

    typedef enum logic [1:0] {RST, REQ, HOLD} state_t;

    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFC;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [7:0]  cnt;
    logic        req;

    // Redirect target drops the byte offset; otherwise fall through (wraps mod 2^32).
    always_comb begin
        pc_next = pc + 32'd4;
        if (PCSrc) begin
            pc_next = Result & PC_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RST;
            pc          <= RESET_PC;
            pc_plus8    <= RESET_PC + 32'd8;
            cnt         <= '0;
            req         <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                RST: begin
                    req   <= 1'b1;
                    state <= REQ;
                end
                REQ: begin
                    if (imem.imem_ack) begin
                        instr       <= imem.imem_rdata;
                        instr_valid <= 1'b1;
                        req         <= 1'b0;
                        cnt         <= '0;
                        state       <= HOLD;
                    end else begin
                        if (cnt != 8'hFF) begin
                            cnt <= cnt + 8'd1;
                        end
                        // Request stays up after a timeout; the flag only reports it.
                        if (cnt >= CNT_LAST) begin
                            fetch_err <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc          <= pc_next;
                        pc_plus8    <= pc_next + 32'd8;
                        instr_valid <= 1'b0;
                        req         <= 1'b1;
                        state       <= REQ;
                    end
                end
                default: begin
                    req   <= 1'b0;
                    state <= RST;
                end
            endcase
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    assign Cond  = instr[31:28];
    assign Op    = instr[27:26];
    assign Funct = instr[25:20];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, timeout/wrap/reset sequences and a
// randomized transaction-level run against a PC/instruction reference model.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Main instance (default parameters)
    fetch_unit_if bus();
    logic        stall, pcsrc;
    logic [31:0] result;
    logic [31:0] instr, pc_plus8;
    logic        instr_valid, fetch_err;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;

    // Short-timeout instance
    fetch_unit_if bus_t();
    logic        stall_t, pcsrc_t;
    logic [31:0] result_t;
    logic [31:0] instr_t, pc_plus8_t;
    logic        instr_valid_t, fetch_err_t;
    logic [3:0]  cond_t;
    logic [1:0]  op_t;
    logic [5:0]  funct_t;

    // Wrap-around reset PC instance
    fetch_unit_if bus_w();
    logic        stall_w, pcsrc_w;
    logic [31:0] result_w;
    logic [31:0] instr_w, pc_plus8_w;
    logic        instr_valid_w, fetch_err_w;
    logic [3:0]  cond_w;
    logic [1:0]  op_w;
    logic [5:0]  funct_w;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem(bus), .stall(stall), .PCSrc(pcsrc), .Result(result),
        .instr(instr), .instr_valid(instr_valid), .Cond(cond), .Op(op), .Funct(funct),
        .pc_plus8(pc_plus8), .fetch_err(fetch_err)
    );

    fetch_unit #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst), .imem(bus_t), .stall(stall_t), .PCSrc(pcsrc_t), .Result(result_t),
        .instr(instr_t), .instr_valid(instr_valid_t), .Cond(cond_t), .Op(op_t), .Funct(funct_t),
        .pc_plus8(pc_plus8_t), .fetch_err(fetch_err_t)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .imem(bus_w), .stall(stall_w), .PCSrc(pcsrc_w), .Result(result_w),
        .instr(instr_w), .instr_valid(instr_valid_w), .Cond(cond_w), .Op(op_w), .Funct(funct_w),
        .pc_plus8(pc_plus8_w), .fetch_err(fetch_err_w)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        pcsrc;
        logic [31:0] result;
        logic [31:0] addr;
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [31:0] pc8;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_wait", {31'd0, bus.imem_req}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] model_pc;
    logic [31:0] data, held;
    int unsigned d, s;
    logic        p;
    logic [31:0] r;

    initial begin
        vecs[0] = '{32'he2800004, 1'b0, 32'h0,        32'h0,   4'he, 2'd0, 6'h28, 32'h8};
        vecs[1] = '{32'he3a00000, 1'b0, 32'h0,        32'h4,   4'he, 2'd0, 6'h3a, 32'hc};
        vecs[2] = '{32'he35100ff, 1'b0, 32'h0,        32'h8,   4'he, 2'd0, 6'h35, 32'h10};
        vecs[3] = '{32'he5901000, 1'b0, 32'h0,        32'hc,   4'he, 2'd1, 6'h19, 32'h14};
        vecs[4] = '{32'h0a00003f, 1'b1, 32'h00000107, 32'h10,  4'h0, 2'd2, 6'h20, 32'h18};
        vecs[5] = '{32'he3a00000, 1'b0, 32'h0,        32'h104, 4'he, 2'd0, 6'h3a, 32'h10c};

        stall = 0; pcsrc = 0; result = 0; bus.imem_ack = 0; bus.imem_rdata = 0;
        stall_t = 0; pcsrc_t = 0; result_t = 0; bus_t.imem_ack = 0; bus_t.imem_rdata = 0;
        stall_w = 0; pcsrc_w = 0; result_w = 0; bus_w.imem_ack = 0; bus_w.imem_rdata = 0;

        // Reset values
        rst = 0;
        repeat (3) tick();
        chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
        chk("rst_addr",  bus.imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_fields", {20'd0, cond, op, funct}, 32'd0);
        chk("rst_pc8",   pc_plus8, 32'h8);
        chk("rst_err",   {31'd0, fetch_err}, 32'd0);
        chk("rst_w_addr", bus_w.imem_addr, 32'hFFFF_FFFC);
        chk("rst_w_pc8",  pc_plus8_w, 32'h4);

        // Timeout (TIMEOUT=4) and wrap (RESET_PC=FFFFFFFC) sequences
        rst = 1;
        tick();
        chk("t_req_e0", {31'd0, bus_t.imem_req}, 32'd1);
        chk("w_req_e0", {31'd0, bus_w.imem_req}, 32'd1);
        chk("w_addr_e0", bus_w.imem_addr, 32'hFFFF_FFFC);
        bus_w.imem_ack = 1; bus_w.imem_rdata = 32'he3a00000;
        tick();
        bus_w.imem_ack = 0;
        chk("w_valid", {31'd0, instr_valid_w}, 32'd1);
        chk("w_instr", instr_w, 32'he3a00000);
        chk("w_pc8_wrap", pc_plus8_w, 32'h4);
        chk("t_err_e1", {31'd0, fetch_err_t}, 32'd0);
        tick();
        chk("w_addr_wrap", bus_w.imem_addr, 32'h0);
        chk("w_req_next",  {31'd0, bus_w.imem_req}, 32'd1);
        chk("w_pc8_next",  pc_plus8_w, 32'h8);
        tick();
        chk("t_err_e3", {31'd0, fetch_err_t}, 32'd0);
        tick();
        chk("t_err_e4", {31'd0, fetch_err_t}, 32'd1);
        chk("t_req_e4", {31'd0, bus_t.imem_req}, 32'd1);
        bus_t.imem_ack = 1; bus_t.imem_rdata = 32'he5901000;
        tick();
        bus_t.imem_ack = 0;
        chk("t_late_valid", {31'd0, instr_valid_t}, 32'd1);
        chk("t_late_instr", instr_t, 32'he5901000);
        chk("t_err_sticky", {31'd0, fetch_err_t}, 32'd1);

        // Main instance has been waiting unacked; its timeout flag must now be set
        repeat (15) tick();
        chk("m_err_set", {31'd0, fetch_err}, 32'd1);
        chk("m_req_wait", {31'd0, bus.imem_req}, 32'd1);

        // Asynchronous reset between edges
        #3 rst = 0;
        #1;
        chk("arst_req",   {31'd0, bus.imem_req}, 32'd0);
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_err",   {31'd0, fetch_err}, 32'd0);
        chk("arst_addr",  bus.imem_addr, 32'h0);
        repeat (2) tick();
        rst = 1;
        tick();

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            wait_req();
            chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].addr);
            bus.imem_ack = 1; bus.imem_rdata = vecs[i].rdata;
            tick();
            bus.imem_ack = 0;
            chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, 32'd1);
            chk($sformatf("v%0d_instr", i), instr, vecs[i].rdata);
            chk($sformatf("v%0d_cond", i),  {28'd0, cond},  {28'd0, vecs[i].cond});
            chk($sformatf("v%0d_op", i),    {30'd0, op},    {30'd0, vecs[i].op});
            chk($sformatf("v%0d_funct", i), {26'd0, funct}, {26'd0, vecs[i].funct});
            chk($sformatf("v%0d_pc8", i),   pc_plus8, vecs[i].pc8);
            chk($sformatf("v%0d_req_lo", i), {31'd0, bus.imem_req}, 32'd0);
            pcsrc = vecs[i].pcsrc; result = vecs[i].result;
            tick();
            pcsrc = 0; result = 0;
            chk($sformatf("v%0d_retired", i), {31'd0, instr_valid}, 32'd0);
            chk($sformatf("v%0d_req_hi", i),  {31'd0, bus.imem_req}, 32'd1);
        end

        // Stall with an ignored redirect, then plain fall-through
        wait_req();
        chk("st_addr", bus.imem_addr, 32'h108);
        bus.imem_ack = 1; bus.imem_rdata = 32'he3a01001;
        tick();
        bus.imem_ack = 0;
        stall = 1; pcsrc = 1; result = 32'h200;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("st_instr", instr, 32'he3a01001);
            chk("st_valid", {31'd0, instr_valid}, 32'd1);
            chk("st_req",   {31'd0, bus.imem_req}, 32'd0);
            chk("st_pc8",   pc_plus8, 32'h110);
        end
        stall = 0; pcsrc = 0; result = 0;
        tick();
        chk("st_next_addr", bus.imem_addr, 32'h10c);
        chk("st_next_req",  {31'd0, bus.imem_req}, 32'd1);

        // Randomized transactions against the reference PC model
        model_pc = 32'h10c;
        for (int n = 0; n < 40; n++) begin
            wait_req();
            chk("rnd_addr", bus.imem_addr, model_pc);
            d = $urandom_range(0, 5);
            for (int k = 0; k < int'(d); k++) begin
                bus.imem_ack = 0; bus.imem_rdata = $urandom;
                stall = 1'($urandom_range(0, 1)); pcsrc = 1'($urandom_range(0, 1)); result = $urandom;
                tick();
                chk("rnd_wait_req",   {31'd0, bus.imem_req}, 32'd1);
                chk("rnd_wait_valid", {31'd0, instr_valid}, 32'd0);
                chk("rnd_wait_addr",  bus.imem_addr, model_pc);
            end
            data = $urandom;
            bus.imem_ack = 1; bus.imem_rdata = data;
            tick();
            bus.imem_ack = 0;
            held = data;
            chk("rnd_valid", {31'd0, instr_valid}, 32'd1);
            chk("rnd_instr", instr, held);
            chk("rnd_cond",  {28'd0, cond},  held >> 28);
            chk("rnd_op",    {30'd0, op},    (held >> 26) & 32'h3);
            chk("rnd_funct", {26'd0, funct}, (held >> 20) & 32'h3f);
            chk("rnd_pc8",   pc_plus8, model_pc + 32'd8);
            s = $urandom_range(0, 3);
            for (int k = 0; k < int'(s); k++) begin
                stall = 1; pcsrc = 1'($urandom_range(0, 1)); result = $urandom;
                bus.imem_ack = 1'($urandom_range(0, 1)); bus.imem_rdata = $urandom;
                tick();
                chk("rnd_stall_instr", instr, held);
                chk("rnd_stall_valid", {31'd0, instr_valid}, 32'd1);
                chk("rnd_stall_req",   {31'd0, bus.imem_req}, 32'd0);
            end
            p = 1'($urandom_range(0, 1));
            r = $urandom;
            stall = 0; pcsrc = p; result = r;
            bus.imem_ack = 1'($urandom_range(0, 1)); bus.imem_rdata = $urandom;
            tick();
            bus.imem_ack = 0;
            pcsrc = 0;
            if (p) model_pc = (r / 4) * 4;
            else   model_pc = model_pc + 32'd4;
            chk("rnd_ret_valid", {31'd0, instr_valid}, 32'd0);
            chk("rnd_ret_req",   {31'd0, bus.imem_req}, 32'd1);
            chk("rnd_ret_addr",  bus.imem_addr, model_pc);
            chk("rnd_ret_pc8",   pc_plus8, model_pc + 32'd8);
        end
        chk("rnd_no_err", {31'd0, fetch_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
